// File: rtl/wr_beat_tracker.sv
// Purpose: queues accepted AW burst lengths, counts W beats against the oldest burst, exports the W beats still owed.
// Latency: every output is registered; a handshake shows up on the outputs one cycle later.
// Backpressure: none; the block only watches the AW/W handshakes and never stalls either channel.

package wr_beat_tracker_pkg;

  typedef struct packed {
    logic [7:0] len;
  } aw_chan_t;

  typedef struct packed {
    logic last;
  } w_chan_t;

  typedef struct packed {
    logic     aw_valid;
    aw_chan_t aw;
    logic     w_valid;
    w_chan_t  w;
  } axi_req_t;

  typedef struct packed {
    logic aw_ready;
    logic w_ready;
  } axi_rsp_t;

endpackage

module wr_beat_tracker #(
  parameter int unsigned MaxWrTxns    = 8,
  parameter int unsigned PrescalerDiv = 1,
  parameter int unsigned AccuCntWidth = 16,
  parameter type         req_t        = wr_beat_tracker_pkg::axi_req_t,
  parameter type         rsp_t        = wr_beat_tracker_pkg::axi_rsp_t
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  req_t                             mst_req_i,
  input  rsp_t                             slv_rsp_i,
  input  logic                             flush_i,
  output logic [AccuCntWidth-1:0]          accum_burst_length_o,
  output logic [$clog2(MaxWrTxns+1)-1:0]   pending_bursts_o,
  output logic                             full_o,
  output logic                             w_unexpected_o,
  output logic                             w_last_err_o,
  output logic                             aw_overflow_o
);

  // A one-entry queue still needs a one-bit pointer to index the storage array.
  localparam int unsigned PtrW  = (MaxWrTxns > 1) ? $clog2(MaxWrTxns) : 1;
  localparam int unsigned CntW  = $clog2(MaxWrTxns + 1);
  // Enough room for every slot holding a 256-beat burst.
  localparam int unsigned RemW  = $clog2(MaxWrTxns * 256 + 1);
  localparam int unsigned Shift = $clog2(PrescalerDiv);
  // Saturation is evaluated at whichever width is larger, so the clamp works both ways.
  localparam int unsigned SatW  = (RemW > AccuCntWidth) ? RemW : AccuCntWidth;
  localparam logic [SatW-1:0] AccMax = SatW'({AccuCntWidth{1'b1}});

  // Burst length storage and queue bookkeeping.
  logic [7:0]      len_mem [MaxWrTxns];
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      beat_cnt_q;
  logic [RemW-1:0] rem_q;

  // Registered outputs that are not plain state copies.
  logic [AccuCntWidth-1:0] accum_q;
  logic                    full_q;
  logic                    w_unexpected_q;
  logic                    w_last_err_q;
  logic                    aw_overflow_q;

  // Per-cycle decode.
  logic                    aw_hs;
  logic                    w_hs;
  logic                    q_empty;
  logic                    q_full;
  logic [7:0]              head_len;
  logic                    w_matched;
  logic                    at_last_beat;
  logic                    head_pop;
  logic                    push;
  logic [8:0]              consumed;
  logic [8:0]              added;
  logic [RemW-1:0]         rem_nxt;
  logic [CntW-1:0]         count_nxt;
  logic [SatW-1:0]         rem_scaled;
  logic [AccuCntWidth-1:0] accum_nxt;

  // Circular pointer advance; wraps explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxWrTxns - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake decode, head selection with empty-queue bypass, and next-state arithmetic.
  always_comb begin
    aw_hs   = mst_req_i.aw_valid & slv_rsp_i.aw_ready;
    w_hs    = mst_req_i.w_valid & slv_rsp_i.w_ready;
    q_empty = (count_q == '0);
    q_full  = (count_q == CntW'(MaxWrTxns));

    // With an empty queue the only burst a beat can belong to is one arriving this cycle.
    head_len     = q_empty ? mst_req_i.aw.len : len_mem[rd_ptr_q];
    w_matched    = w_hs & (~q_empty | aw_hs);
    at_last_beat = (beat_cnt_q == head_len);

    // A disagreeing last still retires the head so the tracker resynchronises.
    head_pop = w_matched & (mst_req_i.w.last | at_last_beat);

    // A same-cycle pop frees the slot a full queue would otherwise refuse.
    push = aw_hs & (~q_full | head_pop);

    // A popped head gives back all of its outstanding beats, not just the current one.
    consumed = 9'd0;
    if (head_pop) begin
      consumed = {1'b0, head_len} + 9'd1 - {1'b0, beat_cnt_q};
    end else if (w_matched) begin
      consumed = 9'd1;
    end

    added = push ? ({1'b0, mst_req_i.aw.len} + 9'd1) : 9'd0;

    rem_nxt   = rem_q + RemW'(added) - RemW'(consumed);
    count_nxt = count_q + CntW'(push) - CntW'(head_pop);

    rem_scaled = SatW'(rem_nxt) >> Shift;
    accum_nxt  = (rem_scaled > AccMax) ? AccMax[AccuCntWidth-1:0]
                                       : rem_scaled[AccuCntWidth-1:0];
  end

  // Burst length storage; contents of free slots are don't-care, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push) begin
      len_mem[wr_ptr_q] <= mst_req_i.aw.len;
    end
  end

  // Queue state, beat counter, remaining-beat total and registered outputs; flush acts like reset.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      beat_cnt_q     <= '0;
      rem_q          <= '0;
      accum_q        <= '0;
      full_q         <= 1'b0;
      w_unexpected_q <= 1'b0;
      w_last_err_q   <= 1'b0;
      aw_overflow_q  <= 1'b0;
    end else begin
      if (head_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (head_pop) begin
        beat_cnt_q <= '0;
      end else if (w_matched) begin
        beat_cnt_q <= beat_cnt_q + 8'd1;
      end
      count_q        <= count_nxt;
      rem_q          <= rem_nxt;
      accum_q        <= accum_nxt;
      full_q         <= (count_nxt == CntW'(MaxWrTxns));
      w_unexpected_q <= w_hs & ~w_matched;
      w_last_err_q   <= w_matched & (mst_req_i.w.last != at_last_beat);
      aw_overflow_q  <= aw_hs & ~push;
    end
  end

  assign accum_burst_length_o = accum_q;
  assign pending_bursts_o     = count_q;
  assign full_o               = full_q;
  assign w_unexpected_o       = w_unexpected_q;
  assign w_last_err_o         = w_last_err_q;
  assign aw_overflow_o        = aw_overflow_q;

endmodule

// File: tb/tb_wr_beat_tracker.sv
// Bench for wr_beat_tracker: vector table, directed wrap-around and saturation sequences, random traffic vs a queue model.
// Two instances: a 4-deep unscaled tracker and an 8-deep tracker scaled by 4 into a 4-bit output.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.

module tb_wr_beat_tracker;
  import wr_beat_tracker_pkg::*;

  localparam int MA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic     rst;
  axi_req_t req_a, req_b;
  axi_rsp_t rsp_a, rsp_b;
  logic     flush_a, flush_b;

  logic [15:0] accum_a;
  logic [2:0]  pend_a;
  logic        full_a, unexp_a, lerr_a, ovf_a;
  logic [3:0]  accum_b;
  logic [3:0]  pend_b;
  logic        full_b, unexp_b, lerr_b, ovf_b;

  wr_beat_tracker #(.MaxWrTxns(MA), .PrescalerDiv(1), .AccuCntWidth(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .mst_req_i(req_a), .slv_rsp_i(rsp_a), .flush_i(flush_a),
    .accum_burst_length_o(accum_a), .pending_bursts_o(pend_a), .full_o(full_a),
    .w_unexpected_o(unexp_a), .w_last_err_o(lerr_a), .aw_overflow_o(ovf_a)
  );

  wr_beat_tracker #(.MaxWrTxns(8), .PrescalerDiv(4), .AccuCntWidth(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .mst_req_i(req_b), .slv_rsp_i(rsp_b), .flush_i(flush_b),
    .accum_burst_length_o(accum_b), .pending_bursts_o(pend_b), .full_o(full_b),
    .w_unexpected_o(unexp_b), .w_last_err_o(lerr_b), .aw_overflow_o(ovf_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model for dut_a ----------------
  // Outstanding work is the list of queued lengths plus beats already taken from the head.
  int m_q[$];
  int m_beats = 0;
  int e_accum, e_pend;
  bit e_full, e_unexp, e_lerr, e_ovf;

  function automatic bit want_last(input int bypass_len);
    if (m_q.size() > 0) return (m_beats == m_q[0]);
    return (bypass_len == 0);
  endfunction

  function automatic void model_step(input bit awv, input bit awr, input int len,
                                     input bit wv, input bit wr, input bit last, input bit flush);
    bit aw_hs, w_hs, pushed;
    int rem;
    aw_hs = awv && awr;
    w_hs  = wv && wr;
    pushed = 0;
    e_unexp = 0; e_lerr = 0; e_ovf = 0;
    if (flush) begin
      m_q.delete();
      m_beats = 0;
    end else begin
      if (w_hs && m_q.size() == 0 && aw_hs) begin
        m_q.push_back(len);
        pushed = 1;
      end
      if (w_hs && m_q.size() > 0) begin
        e_lerr = (last != (m_beats == m_q[0]));
        if (last || m_beats == m_q[0]) begin
          void'(m_q.pop_front());
          m_beats = 0;
        end else begin
          m_beats++;
        end
      end else if (w_hs) begin
        e_unexp = 1;
      end
      if (aw_hs && !pushed) begin
        if (m_q.size() < MA) m_q.push_back(len);
        else e_ovf = 1;
      end
    end
    rem = 0;
    foreach (m_q[i]) rem += m_q[i] + 1;
    rem -= m_beats;
    e_accum = (rem > 65535) ? 65535 : rem;
    e_pend  = m_q.size();
    e_full  = (m_q.size() == MA);
  endfunction

  task automatic drive_a(input bit awv, input bit awr, input int len,
                         input bit wv, input bit wr, input bit last, input bit flush);
    req_a.aw_valid = awv;
    req_a.aw.len   = 8'(len);
    req_a.w_valid  = wv;
    req_a.w.last   = last;
    rsp_a.aw_ready = awr;
    rsp_a.w_ready  = wr;
    flush_a        = flush;
    model_step(awv, awr, len, wv, wr, last, flush);
  endtask

  task automatic check_model_a(input string tag);
    chk({tag, " accum"}, int'(accum_a), e_accum);
    chk({tag, " pending"}, int'(pend_a), e_pend);
    chk({tag, " full"}, int'(full_a), int'(e_full));
    chk({tag, " w_unexpected"}, int'(unexp_a), int'(e_unexp));
    chk({tag, " w_last_err"}, int'(lerr_a), int'(e_lerr));
    chk({tag, " aw_overflow"}, int'(ovf_a), int'(e_ovf));
  endtask

  task automatic drive_b(input bit awv, input int len, input bit wv, input bit last);
    req_b.aw_valid = awv;
    req_b.aw.len   = 8'(len);
    req_b.w_valid  = wv;
    req_b.w.last   = last;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit awv; bit awr; int len; bit wv; bit wr; bit last; bit flush;
    int accum; int pend; bit full; bit unexp; bit lerr; bit ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit awv, input bit awr, input int len, input bit wv,
                              input bit wr, input bit last, input bit flush, input int accum,
                              input int pend, input bit full, input bit unexp, input bit lerr,
                              input bit ovf);
    vec_t v;
    v.awv = awv; v.awr = awr; v.len = len; v.wv = wv; v.wr = wr; v.last = last; v.flush = flush;
    v.accum = accum; v.pend = pend; v.full = full; v.unexp = unexp; v.lerr = lerr; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    int lens[10];
    int k;
    int rem;
    string tag;
    bit awv, awr, wv, wr, last, flush;
    int len;

    rst = 1'b1;
    drive_a(0, 0, 0, 0, 0, 0, 0);
    req_b = '0; rsp_b = '0; flush_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state of both instances.
    chk("reset accum_a", int'(accum_a), 0);
    chk("reset pend_a", int'(pend_a), 0);
    chk("reset full_a", int'(full_a), 0);
    chk("reset pulses_a", int'({unexp_a, lerr_a, ovf_a}), 0);
    chk("reset accum_b", int'(accum_b), 0);
    chk("reset pend_b", int'(pend_b), 0);
    chk("reset full_b", int'(full_b), 0);
    rst = 1'b0;

    //   awv awr len wv wr last flush | accum pend full unexp lerr ovf
    add(1, 1, 3, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0);  // single burst len=3
    add(0, 0, 0, 1, 1, 0, 0,  3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,  2, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0,  4, 1, 0, 0, 0, 0);  // early last on beat 2
    add(0, 0, 0, 1, 1, 0, 0,  3, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0);  // missing last on beat 2
    add(0, 0, 0, 1, 1, 0, 0,  1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 1, 0, 0);  // W with nothing queued
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1, 0,  0, 0, 0, 0, 0, 0);  // same-cycle bypass len=0
    add(1, 0, 5, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0);  // valids without ready
    add(1, 1, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0);  // fill the 4-deep queue
    add(1, 1, 1, 0, 0, 0, 0,  3, 2, 0, 0, 0, 0);
    add(1, 1, 2, 0, 0, 0, 0,  6, 3, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 10, 4, 1, 0, 0, 0);
    add(1, 1, 7, 0, 0, 0, 0, 10, 4, 1, 0, 0, 1);  // AW while full is dropped
    add(1, 1, 4, 1, 1, 1, 0, 14, 4, 1, 0, 0, 0);  // full + pop accepts the push
    add(0, 0, 0, 1, 1, 0, 0, 13, 4, 1, 0, 0, 0);  // mid-beat
    add(1, 1, 2, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0);  // flush outranks AW and W
    add(0, 0, 0, 1, 1, 1, 0,  0, 0, 0, 1, 0, 0);  // stale beat after flush
    add(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive_a(tbl[i].awv, tbl[i].awr, tbl[i].len, tbl[i].wv, tbl[i].wr, tbl[i].last, tbl[i].flush);
      @(posedge clk);
      #1;
      tag = $sformatf("vec%0d", i);
      chk({tag, " accum"}, int'(accum_a), tbl[i].accum);
      chk({tag, " pending"}, int'(pend_a), tbl[i].pend);
      chk({tag, " full"}, int'(full_a), int'(tbl[i].full));
      chk({tag, " w_unexpected"}, int'(unexp_a), int'(tbl[i].unexp));
      chk({tag, " w_last_err"}, int'(lerr_a), int'(tbl[i].lerr));
      chk({tag, " aw_overflow"}, int'(ovf_a), int'(tbl[i].ovf));
    end

    // Wrap-around: 10 back-to-back bursts with W beats every cycle, pointers cycle a 4-deep queue.
    lens = '{2, 0, 3, 1, 0, 4, 2, 1, 0, 3};
    k = 0;
    for (int c = 0; c < 60; c++) begin
      awv = (k < 10) && (m_q.size() < MA);
      len = (k < 10) ? lens[k] : 0;
      wv  = (m_q.size() > 0) || awv;
      last = want_last(len);
      drive_a(awv, 1, len, wv, 1, last, 0);
      if (awv) k++;
      @(posedge clk);
      #1;
      check_model_a($sformatf("wrap c%0d", c));
    end

    // Randomised traffic with occasional stalls, bad lasts, overflows and flushes.
    for (int c = 0; c < 3000; c++) begin
      awv   = ($urandom_range(0, 3) != 0);
      awr   = ($urandom_range(0, 3) != 0);
      len   = $urandom_range(0, 6);
      wv    = ($urandom_range(0, 4) != 0);
      wr    = ($urandom_range(0, 4) != 0);
      last  = want_last(len) ^ ($urandom_range(0, 19) == 0);
      flush = ($urandom_range(0, 99) == 0);
      drive_a(awv, awr, len, wv, wr, last, flush);
      @(posedge clk);
      #1;
      check_model_a($sformatf("rand c%0d", c));
    end
    drive_a(0, 0, 0, 0, 0, 0, 0);

    // Prescale and saturation on dut_b: eight 256-beat bursts give 2048 beats, 2048/4 clamps to 15.
    rsp_b.aw_ready = 1'b1;
    rsp_b.w_ready  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_b(1, 255, 0, 0);
      @(posedge clk);
      #1;
      chk($sformatf("sat push%0d accum", i), int'(accum_b), 15);
      chk($sformatf("sat push%0d pending", i), int'(pend_b), i + 1);
      chk($sformatf("sat push%0d full", i), int'(full_b), (i == 7) ? 1 : 0);
    end
    drive_b(1, 255, 0, 0);
    @(posedge clk);
    #1;
    chk("sat 9th aw_overflow", int'(ovf_b), 1);
    chk("sat 9th pending", int'(pend_b), 8);
    chk("sat 9th accum", int'(accum_b), 15);
    drive_b(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("sat overflow pulse width", int'(ovf_b), 0);

    // Draining exactly 2048 beats must empty it; a wrongly counted 9th burst would leave beats over.
    for (int b = 0; b < 2048; b++) begin
      drive_b(0, 0, 1, (b % 256) == 255);
      @(posedge clk);
      #1;
      rem = 2047 - b;
      chk($sformatf("drain b%0d accum", b), int'(accum_b), ((rem >> 2) > 15) ? 15 : (rem >> 2));
      chk($sformatf("drain b%0d pending", b), int'(pend_b), 8 - (b + 1) / 256);
      chk($sformatf("drain b%0d errs", b), int'({unexp_b, lerr_b}), 0);
    end
    drive_b(0, 0, 1, 1);
    @(posedge clk);
    #1;
    chk("drain extra w_unexpected", int'(unexp_b), 1);
    chk("drain extra accum", int'(accum_b), 0);
    drive_b(0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("drain unexpected pulse width", int'(unexp_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
